// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one MAC TX AXI stream.
// Frames never interleave; frames past MAX_FRAME_BEATS are cut and flagged.
module eth_tx_frame_arbiter #(
    parameter int PORTS           = 4,
    parameter int DATA_WIDTH      = 8,
    parameter bit KEEP_ENABLE     = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH      = (DATA_WIDTH / 8),
    parameter int USER_WIDTH      = 1,
    parameter int MAX_FRAME_BEATS = 1522
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic [PORTS-1:0]              cfg_port_enable,
    output logic                          status_busy,
    output logic [$clog2(PORTS)-1:0]      status_grant,
    output logic [PORTS-1:0]              status_frame_done,
    output logic                          status_oversize
);

    localparam int GW = $clog2(PORTS);
    localparam int CW = $clog2(MAX_FRAME_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           rr_q, rr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    mvalid_q, mvalid_d;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
    logic [KEEP_WIDTH-1:0]   mkeep_q, mkeep_d;
    logic                    mlast_q, mlast_d;
    logic [USER_WIDTH-1:0]   muser_q, muser_d;
    logic [PORTS-1:0]        done_q, done_d;
    logic                    ovs_q, ovs_d;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic [USER_WIDTH-1:0]   sel_user;
    logic                    sel_valid;
    logic                    sel_last;
    logic [PORTS-1:0]        req;
    logic                    req_any;
    logic [GW-1:0]           pick;
    logic [GW-1:0]           idx;
    logic                    slot_free;

    assign slot_free = !mvalid_q || m_axis_tready;

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Search starts one past the last completed grant and wraps.
    always_comb begin
        req     = s_axis_tvalid & cfg_port_enable;
        req_any = 1'b0;
        pick    = rr_q;
        idx     = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = GW'((int'(rr_q) + k) % PORTS);
            if (!req_any && req[idx]) begin
                req_any = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        mvalid_d      = mvalid_q;
        mdata_d       = mdata_q;
        mkeep_d       = mkeep_q;
        mlast_d       = mlast_q;
        muser_d       = muser_q;
        done_d        = '0;
        ovs_d         = 1'b0;
        s_axis_tready = '0;

        if (mvalid_q && m_axis_tready) begin
            mvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                s_axis_tready[grant_q] = slot_free;
                if (sel_valid && slot_free) begin
                    mvalid_d = 1'b1;
                    mdata_d  = sel_data;
                    mkeep_d  = KEEP_ENABLE ? sel_keep : '1;
                    mlast_d  = sel_last;
                    muser_d  = sel_user;
                    cnt_d    = cnt_q + CW'(1);
                    if (sel_last) begin
                        done_d[grant_q] = 1'b1;
                        rr_d            = grant_q;
                        cnt_d           = '0;
                        state_d         = IDLE;
                    end else if (cnt_q == CW'(MAX_FRAME_BEATS - 1)) begin
                        mlast_d    = 1'b1;
                        muser_d[0] = 1'b1;
                        ovs_d      = 1'b1;
                        cnt_d      = '0;
                        state_d    = DROP;
                    end
                end
            end
            DROP: begin
                // Swallow the tail of a truncated frame without output.
                s_axis_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    done_d[grant_q] = 1'b1;
                    rr_d            = grant_q;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= GW'(PORTS - 1);
            cnt_q    <= '0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            mkeep_q  <= '1;
            mlast_q  <= 1'b0;
            muser_q  <= '0;
            done_q   <= '0;
            ovs_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            mkeep_q  <= mkeep_d;
            mlast_q  <= mlast_d;
            muser_q  <= muser_d;
            done_q   <= done_d;
            ovs_q    <= ovs_d;
        end
    end

    assign m_axis_tdata      = mdata_q;
    assign m_axis_tkeep      = mkeep_q;
    assign m_axis_tvalid     = mvalid_q;
    assign m_axis_tlast      = mlast_q;
    assign m_axis_tuser      = muser_q;
    assign status_busy       = (state_q != IDLE);
    assign status_grant      = grant_q;
    assign status_frame_done = done_q;
    assign status_oversize   = ovs_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: 4 ports, 8-bit data, 16-beat cap.
// Source beats carry {port, beat index} so order and origin are self-evident.
module tb_eth_tx_frame_arbiter;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast = '0;
    logic [3:0]  s_tuser = '0;
    logic [7:0]  m_data;
    logic [0:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic [0:0]  m_user;
    logic [3:0]  cfg_en = 4'b1111;
    logic        busy;
    logic [1:0]  grant;
    logic [3:0]  fdone;
    logic        ovs;

    assign s_tkeep = '1;

    eth_tx_frame_arbiter #(
        .PORTS(4),
        .DATA_WIDTH(8),
        .MAX_FRAME_BEATS(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_data),
        .m_axis_tkeep(m_keep),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast(m_last),
        .m_axis_tuser(m_user),
        .cfg_port_enable(cfg_en),
        .status_busy(busy),
        .status_grant(grant),
        .status_frame_done(fdone),
        .status_oversize(ovs)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } fd_t;

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          frames_left[4];
    int          beat[4];
    int          flen[4];
    int          acc_total[4];
    int          last_acc_cyc[4];
    logic [3:0]  ubad = '0;
    logic [3:0]  acc = '0;
    logic [3:0]  seen_rdy = '0;
    int          first_acc = -1;
    int          ovs_cnt = 0;
    int          ovs_cyc = 0;
    bit          toggle = 1'b0;
    bit          gap_chk = 1'b1;
    bit          prev_stall = 1'b0;
    logic [10:0] held = '0;
    beat_t       outq[$];
    fd_t         fdq[$];
    int          exp_ports[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Source model, output sink and monitors; sampling happens 1 ns after negedge.
    always @(negedge clk) begin
        beat_t b;
        fd_t   d;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (beat[i] == flen[i] - 1) begin
                    beat[i] = 0;
                    frames_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
            s_tvalid[i]       = (frames_left[i] > 0);
            s_tdata[i*8 +: 8] = {2'(i), 6'(beat[i])};
            s_tlast[i]        = (beat[i] == flen[i] - 1);
            s_tuser[i]        = ubad[i];
        end
        m_ready = toggle ? ~m_ready : 1'b1;
        #1;
        acc = s_tvalid & s_tready;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                acc_total[i]++;
                last_acc_cyc[i] = cyc;
                if (first_acc < 0) first_acc = cyc;
            end
        end
        seen_rdy = seen_rdy | s_tready;
        if (prev_stall) chk("hold_on_stall", {m_valid, m_data, m_last, m_user}, held);
        prev_stall = m_valid && !m_ready;
        held = {m_valid, m_data, m_last, m_user};
        if (m_valid && m_ready) begin
            b.cyc  = cyc;
            b.data = m_data;
            b.last = m_last;
            b.user = m_user[0];
            outq.push_back(b);
        end
        if (fdone != 4'b0000) begin
            d.cyc = cyc;
            d.v   = fdone;
            fdq.push_back(d);
        end
        if (ovs) begin
            ovs_cnt++;
            ovs_cyc = cyc;
        end
    end

    task automatic clear_logs();
        outq.delete();
        fdq.delete();
        ovs_cnt    = 0;
        first_acc  = -1;
        seen_rdy   = '0;
        prev_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_total[i]    = 0;
            last_acc_cyc[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frames_left[i] = 0;
            beat[i]        = 0;
            flen[i]        = 1;
        end
        acc = '0;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] mask, input int budget);
        int n;
        bit pend;
        n = 0;
        forever begin
            pend = busy || m_valid;
            for (int i = 0; i < 4; i++)
                if (mask[i] && frames_left[i] != 0) pend = 1'b1;
            if (!pend || n >= budget) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_in_budget", n < budget, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int cnt, input int budget);
        int n;
        n = 0;
        while (outq.size() < cnt && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("beats_in_budget", n < budget, 1);
    endtask

    task automatic check_frames(input int len);
        int k;
        chk("beat_count", outq.size(), exp_ports.size() * len);
        chk("frame_done_count", fdq.size(), exp_ports.size());
        for (int f = 0; f < exp_ports.size(); f++) begin
            if (f < fdq.size())
                chk("frame_done_port", fdq[f].v, 4'b0001 << exp_ports[f]);
            for (int j = 0; j < len; j++) begin
                k = f * len + j;
                if (k < outq.size()) begin
                    chk("beat_data", outq[k].data, {2'(exp_ports[f]), 6'(j)});
                    chk("beat_last", outq[k].last, j == len - 1);
                    chk("beat_user", outq[k].user, ubad[exp_ports[f]]);
                    if (j == 0 && f > 0 && gap_chk)
                        chk("idle_gap", outq[k].cyc - outq[k-1].cyc, 2);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            frames_left[i] = 0;
            beat[i]        = 0;
            flen[i]        = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_keep", m_keep, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_ovs", ovs, 0);
        chk("rst_tready", s_tready, 0);

        // Single port, frame of exactly the cap: normal end, no truncation.
        do_reset();
        flen[0] = MAXB;
        frames_left[0] = 1;
        wait_done(4'b0001, 200);
        exp_ports = {0};
        check_frames(MAXB);
        if (outq.size() > 0) chk("first_latency", outq[0].cyc - first_acc, 1);
        if (outq.size() == MAXB && fdq.size() > 0)
            chk("done_with_last", fdq[0].cyc, outq[MAXB-1].cyc);
        chk("single_grant", grant, 0);
        chk("single_no_ovs", ovs_cnt, 0);

        // Four ports, three frames each; port 3 frames are flagged bad.
        do_reset();
        ubad = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            flen[i] = 10;
            frames_left[i] = 3;
        end
        wait_done(4'b1111, 1000);
        exp_ports = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        check_frames(10);
        ubad = '0;

        // Only ports 1 and 3 enabled; disabling port 1 mid-frame is harmless.
        do_reset();
        cfg_en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            flen[i] = 6;
            frames_left[i] = 2;
        end
        wait_beats(14, 500);
        cfg_en = 4'b1000;
        wait_done(4'b1010, 500);
        exp_ports = {1, 3, 1, 3};
        check_frames(6);
        chk("masked_ready", seen_rdy & 4'b0101, 0);
        cfg_en = 4'b1111;

        // Oversize frame on port 2 is cut at the cap and the tail dropped.
        do_reset();
        flen[2] = 20;
        frames_left[2] = 1;
        wait_done(4'b0100, 300);
        chk("trunc_beats", outq.size(), MAXB);
        for (int j = 0; j < MAXB; j++) begin
            if (j < outq.size()) begin
                chk("trunc_data", outq[j].data, {2'd2, 6'(j)});
                chk("trunc_last", outq[j].last, j == MAXB - 1);
                chk("trunc_user", outq[j].user, j == MAXB - 1);
            end
        end
        chk("trunc_ovs_count", ovs_cnt, 1);
        if (outq.size() == MAXB) chk("trunc_ovs_time", ovs_cyc, outq[MAXB-1].cyc);
        chk("trunc_in_beats", acc_total[2], 20);
        chk("trunc_done_count", fdq.size(), 1);
        if (fdq.size() > 0) begin
            chk("trunc_done_port", fdq[0].v, 4'b0100);
            chk("trunc_done_time", fdq[0].cyc, last_acc_cyc[2] + 1);
        end

        // Output ready toggling every cycle.
        do_reset();
        toggle = 1'b1;
        flen[1] = 14;
        frames_left[1] = 1;
        wait_done(4'b0010, 300);
        toggle = 1'b0;
        exp_ports = {1};
        check_frames(14);

        // Reset in the middle of a port 1 frame, then 0 and 1 both request.
        do_reset();
        flen[1] = 12;
        frames_left[1] = 1;
        wait_beats(3, 200);
        rst = 1'b1;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            frames_left[i] = 0;
            beat[i] = 0;
        end
        #2;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tready", s_tready, 0);
        @(posedge clk);
        #1;
        chk("midrst_m_valid_cycle", m_valid, 0);
        clear_logs();
        flen[0] = 4;
        flen[1] = 4;
        frames_left[0] = 1;
        frames_left[1] = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(4'b0011, 200);
        exp_ports = {0, 1};
        check_frames(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
